system_sysid_arb: RTL and testbench
===================================

SYSTEM_SYSID_ARB -- requirements
Module: system_sysid_arb

Interface
REQ-001 Parameter EXPECTED_ID, default 0, 32-bit value the system-ID slave returns at address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 1394485293, 32-bit value the system-ID slave returns at address 1.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 m0_read / m1_read  input  1  read request from master 0 / master 1, held until accepted.
REQ-006 m0_address / m1_address  input  1  word address of the request.
REQ-007 m0_waitrequest / m1_waitrequest  output  1  high = request not accepted this cycle.
REQ-008 m0_readdata / m1_readdata  output  32  returned data, valid only with readdatavalid.
REQ-009 m0_readdatavalid / m1_readdatavalid  output  1  one-cycle pulse marking returned data.
REQ-010 s_address  output  1  address driven to the shared zero-latency read-only slave.
REQ-011 s_readdata  input  32  combinational slave response to s_address.
REQ-012 check_done  output  1  boot ID check finished.
REQ-013 check_fail  output  1  boot ID check mismatch, sticky until reset.

Function
REQ-014 States: BOOT_ID, BOOT_TS, RUN; at most one slave access per cycle.
REQ-015 In RUN, grant is combinational from m0_read, m1_read and the last_grant register.
REQ-016 Single requester: that master is granted in the same cycle.
REQ-017 Both requesting: grant the master not equal to last_grant (round robin); last_grant updates only on a grant.
REQ-018 Granted master: waitrequest low and s_address = its address; the other requester's waitrequest stays high.
REQ-019 mN_waitrequest = mN_read AND NOT granted_N; waitrequest is low when read is low.
REQ-020 Read latency exactly 1: s_readdata is registered in the grant cycle and presented with a one-cycle readdatavalid pulse to the granted master on the next cycle.
REQ-021 readdata holds its last value between pulses; the non-granted master's readdatavalid stays low.
REQ-022 Back-to-back grants to alternating masters are allowed every cycle; sustained throughput is 1 read/cycle.
REQ-023 s_address = 0 when nothing is granted.
REQ-024 Address values are passed through unmodified; no decode or range check.

Reset
REQ-025 Reset values: waitrequest outputs 0, readdatavalid 0, readdata 0, s_address 0, check_done 0, check_fail 0.
REQ-026 Reset state: last_grant = 1, so m0 wins the first contention.
REQ-027 Reset state is BOOT_ID when SYSID_ARB_CHECK_EN is defined, RUN otherwise.
REQ-028 Reset asserted mid-transaction discards the pending readdatavalid; no pulse follows deassertion.

Configuration
REQ-029 Macro SYSID_ARB_CHECK_EN defined: on reset release the block reads address 0 in BOOT_ID and address 1 in BOOT_TS, one cycle each, comparing s_readdata to EXPECTED_ID / EXPECTED_TIMESTAMP.
REQ-030 Macro defined: both masters see waitrequest = read during BOOT_ID/BOOT_TS.
REQ-031 Macro defined: entering RUN sets check_done = 1; check_fail is set if either compare mismatched.
REQ-032 Macro defined: RUN is entered even on mismatch.
REQ-033 Macro undefined: no boot states, check_done tied 1, check_fail tied 0, EXPECTED_* unused.

Structure
REQ-034 Shared package system_sysid_pkg holds the state enum, the SYSID_ADDR_ID = 0 / SYSID_ADDR_TS = 1 constants and the 32-bit data width.
REQ-035 Sub-module system_sysid_rr2 is a 2-way round-robin grant unit (req[1:0], last_grant -> gnt[1:0]); everything else stays in the top level.

Verification
REQ-036 Check enabled, slave returns 0 / 1394485293 -> check_done = 1 at cycle 2 after reset release, check_fail = 0, masters stalled during cycles 0-1.
REQ-037 Check enabled, slave returns 0x12345678 at address 1 -> check_fail = 1, RUN still entered, reads then served normally.
REQ-038 m0 and m1 read continuously from cycle 0 of RUN, addresses 0 and 1 -> grants m0, m1, m0, m1...; each master gets readdatavalid every other cycle with data 0 and 1394485293 respectively.
REQ-039 m1 reads alone at address 1 -> m1_waitrequest low the same cycle, m1_readdatavalid high next cycle with 1394485293; m0 outputs unchanged.
REQ-040 reset_n asserted in the cycle after a grant -> no readdatavalid pulse, all outputs at reset values, m0 wins the first contention after release.

Source files
------------

// File: rtl/system_sysid_pkg.sv
// Shared types and constants for the system-ID arbiter: FSM states, slave word addresses, data width.
package system_sysid_pkg;
  localparam int DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    BOOT_ID = 2'd0,
    BOOT_TS = 2'd1,
    RUN     = 2'd2
  } state_t;
endpackage

// File: rtl/system_sysid_rr2.sv
// Two-way round-robin grant: with both requesting, the master not served last wins.
module system_sysid_rr2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);
  // last_grant: 0 = m0 was served last, 1 = m1 was served last
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_grant)) gnt[0] = 1'b1;
    else if (req[1])                       gnt[1] = 1'b1;
  end
endmodule

// File: rtl/system_sysid_arb.sv
// Two-master arbiter in front of a zero-latency system-ID slave, 1-cycle read latency.
// SYSID_ARB_CHECK_EN adds a boot-time ID/timestamp check before masters are served.
module system_sysid_arb
  import system_sysid_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1394485293
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_read,
  input  logic              m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_address,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              check_done,
  output logic              check_fail
);
`ifdef SYSID_ARB_CHECK_EN
  localparam state_t RESET_STATE = BOOT_ID;
  localparam logic   DONE_RST    = 1'b0;
`else
  // Boot states are unreachable: check_done/check_fail hold their reset constants.
  localparam state_t RESET_STATE = RUN;
  localparam logic   DONE_RST    = 1'b1;
`endif

  state_t     state;
  logic       last_grant;
  logic       id_bad;
  logic [1:0] gnt_rr, gnt;

  system_sysid_rr2 u_rr (
    .req        ({m1_read, m0_read}),
    .last_grant (last_grant),
    .gnt        (gnt_rr)
  );

  // Gating on reset_n keeps waitrequest and s_address at 0 while reset is held.
  assign gnt = (reset_n && state == RUN) ? gnt_rr : 2'b00;

  assign m0_waitrequest = reset_n & m0_read & ~gnt[0];
  assign m1_waitrequest = reset_n & m1_read & ~gnt[1];

  always_comb begin
    s_address = SYSID_ADDR_ID;
    if (gnt[0])                              s_address = m0_address;
    else if (gnt[1])                         s_address = m1_address;
    else if (reset_n && state == BOOT_TS)    s_address = SYSID_ADDR_TS;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= RESET_STATE;
      last_grant       <= 1'b1;
      id_bad           <= 1'b0;
      check_done       <= DONE_RST;
      check_fail       <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
    end else begin
      m0_readdatavalid <= gnt[0];
      m1_readdatavalid <= gnt[1];
      if (gnt[0]) m0_readdata <= s_readdata;
      if (gnt[1]) m1_readdata <= s_readdata;
      if (|gnt)   last_grant  <= gnt[1];
      case (state)
        BOOT_ID: begin
          id_bad <= (s_readdata != EXPECTED_ID);
          state  <= BOOT_TS;
        end
        BOOT_TS: begin
          // RUN is entered regardless of the compare outcome.
          check_fail <= id_bad | (s_readdata != EXPECTED_TIMESTAMP);
          check_done <= 1'b1;
          state      <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_system_sysid_arb.sv
// Scoreboard bench for system_sysid_arb: reference model pushes expected read data, monitor pops on readdatavalid.
module tb_system_sysid_arb;
`ifdef SYSID_ARB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] TS = 32'd1394485293;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        r0, a0, r1, a1;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        s_address, check_done, check_fail;
  logic [31:0] mem [2];

  always #5 clock = ~clock;
  assign s_readdata = mem[s_address];

  system_sysid_arb dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .m0_read          (r0),
    .m0_address       (a0),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_read          (r1),
    .m1_address       (a1),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_readdata       (s_readdata),
    .check_done       (check_done),
    .check_fail       (check_fail)
  );

  int          total = 0, bad = 0;
  logic [31:0] q0[$], q1[$];
  logic [31:0] seen0, seen1;
  bit          mon_en = 1'b0, last_m, exp_fail, directed;
  int          boot_left, dens;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every readdatavalid must match the oldest expected response, exactly one cycle after the grant.
  always @(negedge clock) if (mon_en) begin
    if (m0_readdatavalid) begin
      if (q0.size() == 0) chk("m0_spurious_valid", 1, 0);
      else begin seen0 = q0.pop_front(); chk("m0_readdata", m0_readdata, seen0); end
    end else begin
      chk("m0_missing_valid", q0.size(), 0);
      chk("m0_readdata_hold", m0_readdata, seen0);
    end
    if (m1_readdatavalid) begin
      if (q1.size() == 0) chk("m1_spurious_valid", 1, 0);
      else begin seen1 = q1.pop_front(); chk("m1_readdata", m1_readdata, seen1); end
    end else begin
      chk("m1_missing_valid", q1.size(), 0);
      chk("m1_readdata_hold", m1_readdata, seen1);
    end
  end

  // Holds reset for two cycles, checks reset values, releases on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    mon_en  = 1'b0;
    q0.delete(); q1.delete();
    seen0 = '0; seen1 = '0;
    last_m    = 1'b1;
    boot_left = CHK ? 2 : 0;
    exp_fail  = CHK && (mem[0] !== 32'd0 || mem[1] !== TS);
    repeat (2) @(negedge clock);
    chk("rst_m0_waitrequest", m0_waitrequest, 0);
    chk("rst_m1_waitrequest", m1_waitrequest, 0);
    chk("rst_m0_valid", m0_readdatavalid, 0);
    chk("rst_m1_valid", m1_readdatavalid, 0);
    chk("rst_m0_readdata", m0_readdata, 0);
    chk("rst_m1_readdata", m1_readdata, 0);
    chk("rst_s_address", s_address, 0);
    chk("rst_check_done", check_done, CHK ? 0 : 1);
    chk("rst_check_fail", check_fail, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  // One clock cycle of the reference model; entered and left on a falling edge.
  task automatic run_cycle(input bit rst_after = 1'b0);
    bit boot, g0, g1, exp_sa;
    #1;
    boot   = boot_left > 0;
    g0     = !boot && r0 && (!r1 || last_m);
    g1     = !boot && r1 && !g0;
    exp_sa = g0 ? a0 : g1 ? a1 : (boot && boot_left == 1);
    chk("m0_waitrequest", m0_waitrequest, r0 && !g0);
    chk("m1_waitrequest", m1_waitrequest, r1 && !g1);
    chk("s_address", s_address, exp_sa);
    chk("check_done", check_done, boot_left == 0);
    chk("check_fail", check_fail, boot_left == 0 && exp_fail);
    @(posedge clock);
    if (g0) begin q0.push_back(mem[a0]); last_m = 1'b0; end
    if (g1) begin q1.push_back(mem[a1]); last_m = 1'b1; end
    if (boot) boot_left--;
    #1;
    if (rst_after) do_reset();
    else begin
      if (!directed) begin
        if (!(r0 && !g0)) begin r0 = $urandom_range(0, 99) < dens; a0 = $urandom_range(0, 1); end
        if (!(r1 && !g1)) begin r1 = $urandom_range(0, 99) < dens; a1 = $urandom_range(0, 1); end
      end
      @(negedge clock);
    end
  endtask

  initial begin
    mem[0] = 32'd0;
    mem[1] = TS;
    r0 = 0; a0 = 0; r1 = 0; a1 = 0;
    directed = 1'b1;
    dens = 60;
    do_reset();
    repeat (3) run_cycle();
    // m1 alone at address 1
    r1 = 1; a1 = 1; run_cycle();
    r1 = 0; repeat (2) run_cycle();
    // continuous contention, alternating grants
    r0 = 1; a0 = 0; r1 = 1; a1 = 1;
    repeat (8) run_cycle();
    // steer last grant to m1, grant m0, then reset before the data pulse
    r0 = 0; run_cycle();
    r0 = 1; run_cycle(1'b1);
    repeat (6) run_cycle();
    r0 = 0; r1 = 0; run_cycle();
    // randomized traffic
    directed = 1'b0;
    repeat (300) run_cycle();
    // wrong timestamp in the slave
    directed = 1'b1; r0 = 0; r1 = 0;
    mem[1] = 32'h12345678;
    do_reset();
    directed = 1'b0; dens = 80;
    repeat (60) run_cycle();
    // good contents again: check_fail must clear through reset
    directed = 1'b1; r0 = 0; r1 = 0;
    mem[1] = TS;
    do_reset();
    repeat (4) run_cycle();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
